apb_slave_mem: RTL

//  APB3 completer (slave) with a word-addressed memory and programmable wait states.
//  It is the responder end of the APB link: it receives PSEL/PENABLE transfers from the
//  APB master and answers with PREADY/PRDATA/PSLVERR. It replaces the slave half of the

---
 rtl/apb_slave_mem_pkg.sv | 31 +++
 rtl/apb_slave_mem_if.sv | 30 +++
 rtl/apb_slave_mem_regfile.sv | 35 +++
 rtl/apb_slave_mem.sv | 132 +++++++++++++
 4 files changed

// File: rtl/apb_slave_mem_pkg.sv
// Shared types and constants for the APB completer and its word memory.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_slave_mem_pkg;

    localparam int DEF_ADDR_WIDTH  = 10;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_MEM_DEPTH   = 32;
    localparam int WAIT_STATES_MAX = 15;
    localparam int WAIT_CNT_WIDTH  = 4;

    typedef logic [WAIT_CNT_WIDTH-1:0] wait_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Limit a requested wait-state count to what the counter can hold.
    function automatic wait_cnt_t clamp_wait(input int ws);
        if (ws > WAIT_STATES_MAX) begin
            return wait_cnt_t'(WAIT_STATES_MAX);
        end
        if (ws < 0) begin
            return '0;
        end
        return wait_cnt_t'(ws);
    endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between a requester and a completer.
// Latency: none (wires only).
// Backpressure: completer stretches the access phase by holding pready low.
interface apb_slave_mem_if
    import apb_slave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_slave_mem_regfile.sv
// MEM_DEPTH x DATA_WIDTH word store, cleared by reset.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none, one write port and one read port always available.
module apb_slave_mem_regfile
    import apb_slave_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Every word is wiped on reset; otherwise a single write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer fronting a word-addressed memory with programmable wait states.
// Latency: setup edge to completion edge is WAIT_STATES+1 cycles; outputs registered.
// Backpressure: pready held low for WAIT_STATES access cycles; psel drop aborts.
module apb_slave_mem
    import apb_slave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int WAIT_STATES = 1
) (
    input  logic           apb_clk,
    input  logic           apb_resetn,
    apb_slave_mem_if.slave bus
);

    localparam int        IDX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam wait_cnt_t WAIT_LOAD = clamp_wait(WAIT_STATES);

    apb_state_e            state;
    wait_cnt_t             cnt;        // wait cycles still owed before pready
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  pready_q;
    logic                  pslverr_q;
    logic [DATA_WIDTH-1:0] prdata_q;

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_write;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  mem_we;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return int'(a) < MEM_DEPTH;
    endfunction

    // With zero wait states the response is built at the setup edge, before
    // the address is latched, so look at the live bus while idle.
    assign rd_addr     = (state == ST_IDLE) ? bus.paddr  : addr_q;
    assign rd_write    = (state == ST_IDLE) ? bus.pwrite : write_q;
    assign rd_in_range = addr_ok(rd_addr);
    assign resp_rdata  = (rd_in_range && !rd_write) ? rd_data : '0;

    // Write commits only on the completion edge and only for in-range addresses.
    assign mem_we = (state != ST_IDLE) && bus.psel && bus.penable && pready_q
                    && write_q && addr_ok(addr_q);

    apb_slave_mem_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_regfile (
        .clk   (apb_clk),
        .rst_n (apb_resetn),
        .we    (mem_we),
        .waddr (addr_q[IDX_WIDTH-1:0]),
        .wdata (wdata_q),
        .raddr (rd_addr[IDX_WIDTH-1:0]),
        .rdata (rd_data)
    );

    // Transfer FSM: latch on setup, count down waits, respond, then return to idle.
    always_ff @(posedge apb_clk or negedge apb_resetn) begin
        if (!apb_resetn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // penable without a prior setup phase is ignored here
                    if (bus.psel && !bus.penable) begin
                        addr_q  <= bus.paddr;
                        write_q <= bus.pwrite;
                        wdata_q <= bus.pwdata;
                        state   <= ST_SETUP;
                        if (WAIT_LOAD == '0) begin
                            cnt       <= '0;
                            pready_q  <= 1'b1;
                            pslverr_q <= !rd_in_range;
                            prdata_q  <= resp_rdata;
                        end else begin
                            cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_SETUP, ST_ACCESS: begin
                    if (!bus.psel) begin
                        // abort: nothing is written, response withdrawn
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                    end else if (bus.penable && pready_q) begin
                        // completion edge; a new setup is taken on the next edge
                        state     <= ST_IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                    end else begin
                        state <= ST_ACCESS;
                        if (bus.penable && !pready_q) begin
                            if (cnt <= wait_cnt_t'(1)) begin
                                cnt       <= '0;
                                pready_q  <= 1'b1;
                                pslverr_q <= !rd_in_range;
                                prdata_q  <= resp_rdata;
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;

endmodule
